// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the router input port.
// A host fills a 63-byte payload buffer. On send, the block emits a header
// byte {len, addr}, then len payload bytes, then a parity byte. Parity is the
// XOR of the header and all payload bytes, and it can be inverted for error
// injection. The router's busy signal stalls the stream on any beat.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   wr_en, wr_data      payload byte write; taken only in idle
//   buf_full, buf_count buffer occupancy
//   send, send_addr     start a packet to a port (0..2)
//   corrupt_parity      sampled with send; inverts the parity byte
//   send_ready          idle; a send is accepted
//   send_err            one-cycle pulse on a rejected send
//   busy                router back-pressure; the current beat holds
//   pkt_valid, data_out header/payload beats (parity beat has pkt_valid=0)
//   tx_done             one-cycle pulse after the parity byte is accepted
module router_pkt_tx #(
  parameter int unsigned BUF_DEPTH = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       buf_full,
  output logic [5:0] buf_count,
  input  logic       send,
  input  logic [1:0] send_addr,
  input  logic       corrupt_parity,
  output logic       send_ready,
  output logic       send_err,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_done
);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StParity} state_e;

  state_e     state_q;
  logic [7:0] buf_q [BUF_DEPTH];
  logic [5:0] count_q, len_q, idx_q;
  logic       corrupt_q;
  logic [7:0] parity_q, data_q;
  logic       valid_q, ready_q, full_q, err_q, done_q;

  logic       wr_ok, send_bad, last_beat;
  logic [7:0] header, par_nxt;

  // A write in the same cycle as send is dropped so send sees the prior count.
  assign wr_ok     = (state_q == StIdle) && wr_en && !send && (count_q != 6'(BUF_DEPTH));
  assign send_bad  = (count_q == 6'd0) || (send_addr == 2'b11);
  assign header    = {count_q, send_addr};
  assign par_nxt   = parity_q ^ buf_q[idx_q];
  assign last_beat = (idx_q == len_q - 6'd1);

  // Payload storage has no reset; count_q alone marks which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_ok) buf_q[count_q] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= 6'd0;
      len_q     <= 6'd0;
      idx_q     <= 6'd0;
      corrupt_q <= 1'b0;
      parity_q  <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (send) begin
            if (send_bad) begin
              err_q <= 1'b1;
            end else begin
              len_q     <= count_q;
              corrupt_q <= corrupt_parity;
              data_q    <= header;
              parity_q  <= header;
              valid_q   <= 1'b1;
              ready_q   <= 1'b0;
              state_q   <= StHeader;
            end
          end else if (wr_ok) begin
            count_q <= count_q + 6'd1;
            full_q  <= (count_q + 6'd1 == 6'(BUF_DEPTH));
          end
        end
        StHeader: begin
          if (!busy) begin
            data_q  <= buf_q[0];
            idx_q   <= 6'd0;
            state_q <= StPayload;
          end
        end
        StPayload: begin
          if (!busy) begin
            parity_q <= par_nxt;
            if (last_beat) begin
              valid_q <= 1'b0;
              data_q  <= corrupt_q ? ~par_nxt : par_nxt;
              state_q <= StParity;
            end else begin
              idx_q  <= idx_q + 6'd1;
              data_q <= buf_q[idx_q + 6'd1];
            end
          end
        end
        StParity: begin
          if (!busy) begin
            data_q  <= 8'd0;
            done_q  <= 1'b1;
            count_q <= 6'd0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign buf_full   = full_q;
  assign buf_count  = count_q;
  assign send_ready = ready_q;
  assign send_err   = err_q;
  assign pkt_valid  = valid_q;
  assign data_out   = data_q;
  assign tx_done    = done_q;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet transmitter that produces the router input stream: a header byte {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte.
- Buffers a payload written by a host/testbench, then serialises the packet onto data_out/pkt_valid and honours the router's busy back-pressure.
- Sits in front of the router input port (or in the VIP driver as an RTL stimulus source).
- Parity byte is the XOR of the header and every payload byte, which matches the router's internal parity check.

Parameters:
- BUF_DEPTH, 63, payload buffer depth in bytes; fixed at 63 because the header length field is 6 bits.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write wr_data into the payload buffer.
- wr_data  input  8  payload byte.
- buf_full  output  1  buffer holds 63 bytes.
- buf_count  output  6  bytes currently buffered.
- send  input  1  start transmission of the buffered payload.
- send_addr  input  2  destination port.
- corrupt_parity  input  1  sampled with send; inverts the transmitted parity byte (error injection).
- send_ready  output  1  block idle; send is accepted.
- send_err  output  1  one-cycle pulse: send rejected.
- busy  input  1  router back-pressure.
- pkt_valid  output  1  header/payload byte valid on data_out.
- data_out  output  8  byte to router.
- tx_done  output  1  one-cycle pulse after the parity byte is accepted.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - state=IDLE, buf_count=0, pkt_valid=0, data_out=0, send_err=0, tx_done=0, parity accumulator=0.
  - Reset asserted mid-packet aborts the packet immediately; the buffer is discarded.
- All outputs are registered. send_ready = (state==IDLE). buf_full = (buf_count==63).
- Beat acceptance: a beat is accepted on a rising edge where state is HEADER, PAYLOAD or PARITY and busy==0.
  - When busy==1, data_out, pkt_valid and the internal indices hold unchanged.
- IDLE:
  - wr_en with buf_count<63 stores wr_data at index buf_count, then buf_count+1.
  - wr_en while full is ignored; buffer and count are unchanged.
  - wr_en outside IDLE is ignored.
  - On send:
    - If buf_count==0 or send_addr==2'b11: send_err=1 for one cycle, remain IDLE, buffer kept.
    - Otherwise latch addr, len=buf_count and corrupt flag, and go to HEADER.
    - On the next cycle pkt_valid=1 and data_out={len,addr}; parity accumulator is loaded with the header.
  - wr_en and send in the same cycle: the write is ignored and send uses the prior count.
- HEADER → PAYLOAD:
  - On acceptance, data_out=buf[0] and pkt_valid stays 1.
- PAYLOAD:
  - Each accepted byte i is XORed into the accumulator.
  - If i<len-1: data_out=buf[i+1].
  - If i==len-1: go to PARITY; pkt_valid=0; data_out = final parity (XOR 8'hFF if the corrupt flag is set).
  - pkt_valid never drops between the header and the last payload byte.
- PARITY:
  - Parity byte is held while busy==1.
  - On acceptance: data_out=0, tx_done=1 for one cycle, buf_count=0, go to IDLE.
  - The next send is accepted no earlier than the cycle after tx_done.
- State machine: IDLE → HEADER → PAYLOAD → PARITY → IDLE. There are no other transitions except reset.
- Latency:
  - Header appears 1 cycle after send is accepted.
  - With busy=0 throughout, a packet occupies len+2 consecutive cycles, and tx_done is asserted on cycle len+3.

Test Plan:
- Write 0x11,0x22,0x33, send addr=1, busy=0 → data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0, tx_done the next cycle, buf_count=0.
- Same packet with busy=1 for 3 cycles during byte 0x22 → 0x22 held 4 cycles, pkt_valid stays 1, sequence and parity unchanged.
- Write 63 bytes of 0x01, then a 64th write → buf_full=1, count stays 63; send addr=2 → header 0xFE, parity 0xFF (0xFE XOR 63 ones).
- send with buf_count=0, and separately send_addr=3 with 2 bytes buffered → send_err pulses, pkt_valid stays 0, buffer intact.
- Packet 0x11,0x22,0x33 to addr 1 with corrupt_parity=1 → parity byte 0xF2.
- reset asserted during a payload byte → next cycle pkt_valid=0, data_out=0, send_ready=1, buf_count=0.
